im_loader: RTL and testbench

Program loader and access arbiter for the 64-entry instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written into sequential instruction-memory entries. During a load it takes the memory's address/write port away from the CPU fetch path and holds the CPU stalled; otherwise it passes the fetch address straight through.

---
 rtl/im_loader.sv | 130 +++++++++++++
 tb/tb_im_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Program loader and fetch/write arbiter for the 64-entry instruction memory.
// Define IM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module im_loader #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [AW-1:0] load_words,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic [AW-1:0] pc_addr,
    output logic [AW-1:0] im_addr,
    output logic [31:0]   im_wdata,
    output logic          im_we,
    output logic          cpu_stall,
    output logic          busy,
    output logic          load_done,
    output logic          load_err
);

`ifdef IM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] count;
    logic [AW-1:0] ptr;
    logic [1:0]    byte_idx;
    logic [23:0]   shreg;
    logic [31:0]   word;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]    sum;
    logic          err;
`endif

    // A count of 0 makes count-1 wrap to the last entry, so it loads the full memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            ptr      <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            word     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum      <= '0;
            err      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        count    <= load_words;
                        ptr      <= '0;
                        byte_idx <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                        sum      <= '0;
                        err      <= 1'b0;
`endif
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (byte_valid) begin
                        shreg    <= {shreg[15:0], byte_data};
                        byte_idx <= byte_idx + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                        sum      <= sum + byte_data;
`endif
                        if (byte_idx == 2'd3) begin
                            word  <= {shreg, byte_data};
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (ptr == count - ONE) begin
`ifdef IM_LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= DONE;
`endif
                    end else begin
                        ptr   <= ptr + ONE;
                        state <= RECV;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (byte_valid) begin
                        if (byte_data != sum) begin
                            err <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    assign byte_ready = (state == RECV) || (state == CSUM);
    assign load_err   = err;
`else
    assign byte_ready = (state == RECV);
    assign load_err   = 1'b0;
`endif

    // The CPU owns the address port only while idle.
    assign im_addr   = (state == IDLE) ? pc_addr : ptr;
    assign im_wdata  = word;
    assign im_we     = (state == WRITE);
    assign busy      = (state != IDLE);
    assign cpu_stall = (state != IDLE);
    assign load_done = (state == DONE);

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: vector table for a 2-word load plus hand-written
// sequences for handshake gaps, full-depth load, mid-load reset and checksum.
module tb_im_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [5:0]  load_words;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [5:0]  pc_addr;
    logic [5:0]  im_addr;
    logic [31:0] im_wdata;
    logic        im_we;
    logic        cpu_stall;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int passed = 0;
    int total  = 0;

    logic [5:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cnt = 0;
    logic [7:0]  stream [0:255];

    typedef struct {
        logic        start;
        logic [7:0]  b;
        logic        v;
        logic        e_ready;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    im_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_words (load_words),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .pc_addr    (pc_addr),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .im_we      (im_we),
        .cpu_stall  (cpu_stall),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent record of every memory write and done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (im_we) begin
                wr_addr_q.push_back(im_addr);
                wr_data_q.push_back(im_wdata);
            end
            if (load_done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    function automatic vec_t mk(logic st, logic [7:0] b, logic v, logic er, logic ew,
                                logic [5:0] ea, logic [31:0] ed, logic es, logic edn);
        vec_t r;
        r.start = st; r.b = b; r.v = v; r.e_ready = er; r.e_we = ew;
        r.e_addr = ea; r.e_wdata = ed; r.e_stall = es; r.e_done = edn;
        return r;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        load_start = v.start;
        load_words = 6'd2;
        pc_addr    = 6'h15;
        byte_data  = v.b;
        byte_valid = v.v;
    endtask

    task automatic check_output(input int i, input vec_t v);
        check($sformatf("vec%0d.ready", i), 32'(byte_ready), 32'(v.e_ready));
        check($sformatf("vec%0d.we", i),    32'(im_we),      32'(v.e_we));
        check($sformatf("vec%0d.addr", i),  32'(im_addr),    32'(v.e_addr));
        check($sformatf("vec%0d.wdata", i), im_wdata,        v.e_wdata);
        check($sformatf("vec%0d.stall", i), 32'(cpu_stall),  32'(v.e_stall));
        check($sformatf("vec%0d.busy", i),  32'(busy),       32'(v.e_stall));
        check($sformatf("vec%0d.done", i),  32'(load_done),  32'(v.e_done));
    endtask

    // Streams nbytes from stream[] honouring the handshake; appends the checksum when enabled.
    task automatic run_load(input logic [5:0] nw, input int nbytes, input bit toggle, input bit bad_csum);
        int idx = 0;
        int cyc = 0;
        int tot;
        bit gap = 0;
        logic [7:0] sum = 8'h00;
`ifdef IM_LOADER_CHECKSUM_EN
        tot = nbytes + 1;
`else
        tot = nbytes;
`endif
        load_start = 1'b1;
        load_words = nw;
        byte_valid = 1'b0;
        #1;
        tick();
        load_start = 1'b0;
        while (idx < tot && cyc < 3000) begin
            byte_data  = (idx < nbytes) ? stream[idx] : (bad_csum ? sum + 8'h01 : sum);
            byte_valid = toggle ? !gap : 1'b1;
            gap = !gap;
            if (byte_valid && byte_ready) begin
                if (idx < nbytes) sum = sum + stream[idx];
                idx++;
            end
            tick();
            cyc++;
        end
        byte_valid = 1'b0;
        check("feed.all_bytes_accepted", 32'(idx), 32'(tot));
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (load_done) begin
                seen = 1;
                break;
            end
            tick();
        end
        check({name, ".done_seen"}, 32'(seen), 32'd1);
        tick();
        check({name, ".stall_after"}, 32'(cpu_stall), 32'd0);
        check({name, ".done_one_cycle"}, 32'(load_done), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_w;

        // Reset with random inputs
        rst_n = 1'b0;
        load_start = 1'b0; load_words = '0; byte_data = '0; byte_valid = 1'b0; pc_addr = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            load_start = 1'($urandom);
            load_words = 6'($urandom);
            byte_data  = 8'($urandom);
            byte_valid = 1'($urandom);
            pc_addr    = 6'($urandom);
            #1;
            check("rst.ready", 32'(byte_ready), 0);
            check("rst.we",    32'(im_we),      0);
            check("rst.wdata", im_wdata,        0);
            check("rst.stall", 32'(cpu_stall),  0);
            check("rst.busy",  32'(busy),       0);
            check("rst.done",  32'(load_done),  0);
            check("rst.err",   32'(load_err),   0);
            check("rst.addr",  32'(im_addr),    32'(pc_addr));
        end
        load_start = 1'b0; byte_valid = 1'b0; pc_addr = 6'h15;
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst.addr", 32'(im_addr), 32'h15);
        check("post_rst.busy", 32'(busy), 0);

        // 2-word load, table driven (load_start repeated in RECV must be ignored)
        clear_log();
        vecs.push_back(mk(1, 8'h00, 0, 0, 0, 6'h15, 32'h0,        0, 0));
        vecs.push_back(mk(0, 8'h20, 1, 1, 0, 6'h00, 32'h0,        1, 0));
        vecs.push_back(mk(1, 8'h08, 1, 1, 0, 6'h00, 32'h0,        1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 6'h00, 32'h0,        1, 0));
        vecs.push_back(mk(0, 8'h20, 1, 1, 0, 6'h00, 32'h0,        1, 0));
        vecs.push_back(mk(0, 8'h20, 1, 0, 1, 6'h00, 32'h20080020, 1, 0));
        vecs.push_back(mk(0, 8'h20, 1, 1, 0, 6'h01, 32'h20080020, 1, 0));
        vecs.push_back(mk(0, 8'h09, 1, 1, 0, 6'h01, 32'h20080020, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 6'h01, 32'h20080020, 1, 0));
        vecs.push_back(mk(0, 8'h37, 1, 1, 0, 6'h01, 32'h20080020, 1, 0));
        vecs.push_back(mk(0, 8'h55, 1, 0, 1, 6'h01, 32'h20090037, 1, 0));
`ifdef IM_LOADER_CHECKSUM_EN
        vecs.push_back(mk(0, 8'hA8, 1, 1, 0, 6'h01, 32'h20090037, 1, 0));
`endif
        vecs.push_back(mk(0, 8'h55, 1, 0, 0, 6'h01, 32'h20090037, 1, 1));
        vecs.push_back(mk(0, 8'h55, 1, 0, 0, 6'h15, 32'h20090037, 0, 0));
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output(i, vecs[i]);
            tick();
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
        check("tbl.nwrites", 32'(wr_addr_q.size()), 2);
        if (wr_addr_q.size() == 2) begin
            check("tbl.w0.addr", 32'(wr_addr_q[0]), 0);
            check("tbl.w0.data", wr_data_q[0], 32'h20080020);
            check("tbl.w1.addr", 32'(wr_addr_q[1]), 1);
            check("tbl.w1.data", wr_data_q[1], 32'h20090037);
        end
        check("tbl.err", 32'(load_err), 0);

        // 1-word load with byte_valid toggling every cycle
        clear_log();
        stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE; stream[3] = 8'hEF;
        run_load(6'd1, 4, 1'b1, 1'b0);
        wait_done("toggle");
        check("toggle.nwrites", 32'(wr_addr_q.size()), 1);
        if (wr_addr_q.size() == 1) begin
            check("toggle.addr", 32'(wr_addr_q[0]), 0);
            check("toggle.data", wr_data_q[0], 32'hDEADBEEF);
        end
        check("toggle.ndone", 32'(done_cnt), 1);
        check("toggle.err", 32'(load_err), 0);

        // load_words = 0 loads all 64 words in order
        clear_log();
        for (int i = 0; i < 256; i++) stream[i] = 8'(i * 7 + 3);
        run_load(6'd0, 256, 1'b0, 1'b0);
        wait_done("full");
        check("full.nwrites", 32'(wr_addr_q.size()), 64);
        check("full.ndone", 32'(done_cnt), 1);
        if (wr_addr_q.size() == 64) begin
            for (int w = 0; w < 64; w++) begin
                exp_w = {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
                check($sformatf("full.w%0d.addr", w), 32'(wr_addr_q[w]), 32'(w));
                check($sformatf("full.w%0d.data", w), wr_data_q[w], exp_w);
            end
        end

`ifdef IM_LOADER_CHECKSUM_EN
        // Checksum match then mismatch
        stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h03; stream[3] = 8'h04;
        run_load(6'd1, 4, 1'b0, 1'b0);
        wait_done("csum_ok");
        check("csum_ok.err", 32'(load_err), 0);
        run_load(6'd1, 4, 1'b0, 1'b1);
        wait_done("csum_bad");
        check("csum_bad.err", 32'(load_err), 1);
        tick(); tick();
        check("csum_bad.err_held", 32'(load_err), 1);
`endif

        // Asynchronous reset after 6 accepted bytes of a 2-word load
        clear_log();
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        stream[4] = 8'h55; stream[5] = 8'h66; stream[6] = 8'h77; stream[7] = 8'h88;
        load_start = 1'b1; load_words = 6'd2; byte_valid = 1'b0;
        #1;
        tick();
        load_start = 1'b0;
        check("midrst.err_cleared", 32'(load_err), 0);
        begin
            int acc = 0;
            for (int c = 0; c < 40 && acc < 6; c++) begin
                byte_data  = stream[acc];
                byte_valid = 1'b1;
                if (byte_ready) acc++;
                tick();
            end
            check("midrst.accepted", 32'(acc), 6);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy",  32'(busy),       0);
        check("midrst.stall", 32'(cpu_stall),  0);
        check("midrst.ready", 32'(byte_ready), 0);
        check("midrst.addr",  32'(im_addr),    32'(pc_addr));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        byte_valid = 1'b0;
        check("midrst.nwrites", 32'(wr_addr_q.size()), 1);
        if (wr_addr_q.size() >= 1) begin
            check("midrst.w0.addr", 32'(wr_addr_q[0]), 0);
            check("midrst.w0.data", wr_data_q[0], 32'h11223344);
        end
        check("midrst.ndone", 32'(done_cnt), 0);
        check("midrst.idle_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
